inv_key_schedule: RTL and testbench
===================================

INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; ports SHALL be as listed in REQ-002..REQ-011.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 kld  input  1  load strobe; key is sampled on a clk edge while kld=1.
REQ-005 key  input  128  AES-128 cipher key; bits 127:96 form word w0.
REQ-006 next  input  1  request to step to the previous round key.
REQ-007 busy  output  1  high while forward expansion runs.
REQ-008 kvalid  output  1  high while wo_0..wo_3 hold a valid round key.
REQ-009 round  output  4  index (10..0) of the round key on wo_0..wo_3.
REQ-010 wo_0, wo_1, wo_2, wo_3  output  32 each  current round-key words, w0 first.
REQ-011 key_err  output  1  round-0 self-check mismatch flag (see Configuration).

Function
REQ-012 The FSM SHALL have three states: IDLE, EXPAND and READY.
REQ-013 kld=1 SHALL load key into w0..w3, set round=0 and enter EXPAND from any state, including mid-EXPAND or mid-READY.
REQ-014 In EXPAND, each cycle SHALL apply the standard forward AES-128 round-key recurrence and increment round, using RotWord, SubWord and Rcon(round+1).
REQ-015 EXPAND SHALL last exactly 10 cycles; kld sampled at edge t SHALL give busy=0, kvalid=1 and round=10 after edge t+10.
REQ-016 In READY, next=1 with round>0 SHALL, at the next edge, replace the key with the previous round key and decrement round; this is a single-cycle step.
REQ-017 The inverse step SHALL compute: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^Rcon(round).
REQ-018 Rcon(i) SHALL be {rc_i,24'h0}, with rc_i = 01,02,04,08,10,20,40,80,1b,36 for i=1..10, taken from an internal 10-entry table.
REQ-019 next=1 in READY with round=0 SHALL move the FSM to IDLE, with kvalid=0, round=0, and wo_* holding their value.
REQ-020 next SHALL be ignored in IDLE and EXPAND.
REQ-021 If kld and next are both 1 in the same cycle, kld SHALL take priority.
REQ-022 busy SHALL be 1 exactly in EXPAND, and kvalid SHALL be 1 exactly in READY.
REQ-023 SubWord SHALL use four combinational S-box lookups; no lookup SHALL add pipeline latency.

Reset
REQ-024 On rst_n=0, asynchronously: FSM=IDLE, w0..w3=0, round=0, busy=0, kvalid=0, key_err=0.
REQ-025 Once rst_n is released, the block SHALL act only on kld.

Configuration
REQ-026 The macro INV_KEY_SELFCHECK_EN SHALL control the round-0 self-check.
REQ-027 With INV_KEY_SELFCHECK_EN defined, the block SHALL store the loaded key in a 128-bit register.
REQ-028 With INV_KEY_SELFCHECK_EN defined, on entry to round 0 in READY it SHALL compare that register with {wo_0,wo_1,wo_2,wo_3}.
REQ-029 With INV_KEY_SELFCHECK_EN defined, a mismatch SHALL set key_err, which SHALL stay set until the next kld or reset.
REQ-030 Without INV_KEY_SELFCHECK_EN, key_err SHALL be tied to 0 and no key register SHALL exist.

Verification
REQ-031 Load FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> 10 cycles later kvalid=1, round=10, wo = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
REQ-032 From REQ-031, pulse next once -> round=9, wo = ac7766f3 19fadc21 28d12941 575c006e.
REQ-033 Hold next high from round 10 -> round 1 gives a0fafe17 88542cb1 23a33939 2a6c7605, round 0 gives the original key, key_err=0, then one more step gives IDLE with kvalid=0.
REQ-034 Assert kld during EXPAND cycle 5, or during READY at round 4, with key 000102030405060708090a0b0c0d0e0f -> restart; round 10 gives 13111d7f e3944a17 f307a78b 4d2b30c5.
REQ-035 Drive next during EXPAND and IDLE, and drive kld and next together in READY -> next is ignored and kld wins.
REQ-036 Assert rst_n=0 mid-EXPAND -> busy, kvalid, round and wo_* all read 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/inv_key_schedule.sv
// AES-128 key schedule: forward-expands a loaded key to round 10, then steps back one round key per request.
// Latency: 10 cycles from kld to round 10; each inverse step takes 1 cycle. No backpressure: next is a level request.
// Optional round-0 key self-check is compiled in with INV_KEY_SELFCHECK_EN.
module inv_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         kld,
    input  logic [127:0] key,
    input  logic         next,
    output logic         busy,
    output logic         kvalid,
    output logic [3:0]   round,
    output logic [31:0]  wo_0,
    output logic [31:0]  wo_1,
    output logic [31:0]  wo_2,
    output logic [31:0]  wo_3,
    output logic         key_err
);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_e;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte of the packed table, so index by the complement.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    // Entry i holds rc_(i+1).
    function automatic logic [31:0] rcon(input logic [3:0] i);
        logic [7:0] rc;
        case (i)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h0};
    endfunction

    state_e      state_q, state_d;
    logic [31:0] w0_q, w1_q, w2_q, w3_q;
    logic [31:0] w0_d, w1_d, w2_d, w3_d;
    logic [3:0]  round_q, round_d;
    logic [31:0] sub_in, t;
    logic [3:0]  rc_idx;

    always_comb begin
        state_d = state_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        round_d = round_q;
        // One SubWord path serves both directions: forward uses w3, inverse uses the recovered w3.
        sub_in  = (state_q == EXPAND) ? w3_q : (w3_q ^ w2_q);
        rc_idx  = (state_q == EXPAND) ? round_q : (round_q - 4'd1);
        t       = sub_rot(sub_in) ^ rcon(rc_idx);
        if (kld) begin
            {w0_d, w1_d, w2_d, w3_d} = key;
            round_d = 4'd0;
            state_d = EXPAND;
        end else begin
            case (state_q)
                EXPAND: begin
                    w0_d    = w0_q ^ t;
                    w1_d    = w1_q ^ w0_d;
                    w2_d    = w2_q ^ w1_d;
                    w3_d    = w3_q ^ w2_d;
                    round_d = round_q + 4'd1;
                    if (round_q == 4'd9) state_d = READY;
                end
                READY: begin
                    if (next) begin
                        if (round_q == 4'd0) begin
                            state_d = IDLE;
                        end else begin
                            w3_d    = w3_q ^ w2_q;
                            w2_d    = w2_q ^ w1_q;
                            w1_d    = w1_q ^ w0_q;
                            w0_d    = w0_q ^ t;
                            round_d = round_q - 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            round_q <= round_d;
        end
    end

`ifdef INV_KEY_SELFCHECK_EN
    logic [127:0] key_q, key_d;
    logic         key_err_q, key_err_d;

    // Compared on the step that lands on round 0, so the flag is valid as round 0 appears.
    always_comb begin
        key_d     = key_q;
        key_err_d = key_err_q;
        if (kld) begin
            key_d     = key;
            key_err_d = 1'b0;
        end else if (state_q == READY && next && round_q == 4'd1 &&
                     {w0_d, w1_d, w2_d, w3_d} != key_q) begin
            key_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q     <= '0;
            key_err_q <= 1'b0;
        end else begin
            key_q     <= key_d;
            key_err_q <= key_err_d;
        end
    end

    assign key_err = key_err_q;
`else
    assign key_err = 1'b0;
`endif

    assign busy   = (state_q == EXPAND);
    assign kvalid = (state_q == READY);
    assign round  = round_q;
    assign wo_0   = w0_q;
    assign wo_1   = w1_q;
    assign wo_2   = w2_q;
    assign wo_3   = w3_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: FIPS-197 vectors, restarts, ignored next, async reset.
module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         kld;
    logic [127:0] key;
    logic         next;
    logic         busy, kvalid, key_err;
    logic [3:0]   round;
    logic [31:0]  wo_0, wo_1, wo_2, wo_3;

    inv_key_schedule dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .kld    (kld),
        .key    (key),
        .next   (next),
        .busy   (busy),
        .kvalid (kvalid),
        .round  (round),
        .wo_0   (wo_0),
        .wo_1   (wo_1),
        .wo_2   (wo_2),
        .wo_3   (wo_3),
        .key_err(key_err)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KA   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KA1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KA9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] KA10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KB   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KB10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        string        name;
        logic         kld;
        logic [127:0] key;
        logic         nxt;
        int           hold;
        int           idle;
        logic         e_busy;
        logic         e_kvalid;
        logic [3:0]   e_round;
        logic         chk_wo;
        logic [127:0] e_wo;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;
    vec_t vecs[17];

    function automatic vec_t mk(string n, logic kl, logic [127:0] k, logic nx, int h, int id,
                                logic eb, logic ek, logic [3:0] er, logic cw, logic [127:0] ew);
        vec_t v;
        v.name = n; v.kld = kl; v.key = k; v.nxt = nx; v.hold = h; v.idle = id;
        v.e_busy = eb; v.e_kvalid = ek; v.e_round = er; v.chk_wo = cw; v.e_wo = ew;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(string n, logic eb, logic ek, logic [3:0] er, logic cw, logic [127:0] ew);
        logic [127:0] got;
        got = {wo_0, wo_1, wo_2, wo_3};
        n_vec++;
        if (busy !== eb || kvalid !== ek || round !== er || key_err !== 1'b0 || (cw && got !== ew)) begin
            n_miss++;
            $display("FAIL %s: got busy=%b kvalid=%b round=%0d key_err=%b wo=%h; want busy=%b kvalid=%b round=%0d key_err=0 wo=%h (wo checked=%b)",
                     n, busy, kvalid, round, key_err, got, eb, ek, er, ew, cw);
        end
    endtask

    initial begin
        vecs[0]  = mk("next_in_idle",    0, '0, 1, 2, 0,  0, 0, 4'd0,  1, '0);
        vecs[1]  = mk("load_a",          1, KA, 0, 1, 0,  1, 0, 4'd0,  1, KA);
        vecs[2]  = mk("next_in_expand",  0, '0, 1, 4, 5,  1, 0, 4'd9,  1, KA9);
        vecs[3]  = mk("a_round10",       0, '0, 0, 0, 1,  0, 1, 4'd10, 1, KA10);
        vecs[4]  = mk("a_round10_hold",  0, '0, 0, 0, 3,  0, 1, 4'd10, 1, KA10);
        vecs[5]  = mk("a_step_r9",       0, '0, 1, 1, 0,  0, 1, 4'd9,  1, KA9);
        vecs[6]  = mk("a_step_r1",       0, '0, 1, 8, 0,  0, 1, 4'd1,  1, KA1);
        vecs[7]  = mk("a_step_r0",       0, '0, 1, 1, 0,  0, 1, 4'd0,  1, KA);
        vecs[8]  = mk("a_to_idle",       0, '0, 1, 1, 0,  0, 0, 4'd0,  1, KA);
        vecs[9]  = mk("idle_next_again", 0, '0, 1, 2, 0,  0, 0, 4'd0,  1, KA);
        vecs[10] = mk("load_b_r4",       1, KB, 0, 1, 4,  1, 0, 4'd4,  0, '0);
        vecs[11] = mk("reload_mid_exp",  1, KB, 0, 1, 10, 0, 1, 4'd10, 1, KB10);
        vecs[12] = mk("b_step_r4",       0, '0, 1, 6, 0,  0, 1, 4'd4,  0, '0);
        vecs[13] = mk("kld_and_next",    1, KB, 1, 1, 0,  1, 0, 4'd0,  1, KB);
        vecs[14] = mk("b_round10",       0, '0, 0, 0, 10, 0, 1, 4'd10, 1, KB10);
        vecs[15] = mk("b_step_r0",       0, '0, 1, 10, 0, 0, 1, 4'd0,  1, KB);
        vecs[16] = mk("b_to_idle",       0, '0, 1, 1, 0,  0, 0, 4'd0,  1, KB);

        rst_n = 1'b0; kld = 1'b0; next = 1'b0; key = '0;
        #1;
        check("reset_state", 0, 0, 4'd0, 1, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].hold > 0) begin
                kld  = vecs[i].kld;
                key  = vecs[i].key;
                next = vecs[i].nxt;
                repeat (vecs[i].hold) tick();
            end
            kld = 1'b0; next = 1'b0; key = '0;
            repeat (vecs[i].idle) tick();
            check(vecs[i].name, vecs[i].e_busy, vecs[i].e_kvalid, vecs[i].e_round,
                  vecs[i].chk_wo, vecs[i].e_wo);
        end

        // Asynchronous reset in the middle of expansion, sampled between clock edges.
        kld = 1'b1; key = KA;
        tick();
        kld = 1'b0; key = '0;
        repeat (3) tick();
        check("pre_reset_r3", 1, 0, 4'd3, 0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 0, 0, 4'd0, 1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        next = 1'b1;
        repeat (2) tick();
        next = 1'b0;
        check("post_reset_next", 0, 0, 4'd0, 1, '0);
        kld = 1'b1; key = KB;
        tick();
        kld = 1'b0; key = '0;
        repeat (10) tick();
        check("post_reset_load", 0, 1, 4'd10, 1, KB10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
